// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: bus widths and the
// write-side controller state encoding.
package conv_pkg;

    localparam int unsigned DATA_W = 18;
    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DIM_W  = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/conv_out_writer_addr_walk_2d.sv
// Row-major 2-D position walker: column/row counters plus a running row base
// address advanced by the pitch, so no multiplier is needed.
module addr_walk_2d #(
    parameter int unsigned DIM_W  = 9,
    parameter int unsigned ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              step_i,
    input  logic [DIM_W-1:0]  width_i,
    input  logic [DIM_W-1:0]  height_i,
    input  logic [DIM_W-1:0]  pitch_i,
    output logic [DIM_W-1:0]  col_o,
    output logic [DIM_W-1:0]  row_o,
    output logic [ADDR_W-1:0] row_base_o,
    output logic              last_o
);

    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              col_last;
    logic              row_last;

    assign col_last = (col_q == (width_i - DIM_W'(1)));
    assign row_last = (row_q == (height_i - DIM_W'(1)));

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        if (load_i) begin
            col_d      = '0;
            row_d      = '0;
            row_base_d = base_i;
        end else if (step_i && !(col_last && row_last)) begin
            // Final element holds the counters instead of wrapping.
            if (!col_last) begin
                col_d = col_q + DIM_W'(1);
            end else begin
                col_d      = '0;
                row_d      = row_q + DIM_W'(1);
                row_base_d = row_base_q + ADDR_W'(pitch_i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
        end
    end

    assign col_o      = col_q;
    assign row_o      = row_q;
    assign row_base_o = row_base_q;
    assign last_o     = col_last && row_last;

endmodule

// File: rtl/conv_out_writer.sv
// Write-side address controller: accepts result words over valid/ready and
// writes them row-major into a width x height window of the output RAM.
module conv_out_writer #(
    parameter int unsigned DATA_W = conv_pkg::DATA_W,
    parameter int unsigned ADDR_W = conv_pkg::ADDR_W,
    parameter int unsigned DIM_W  = conv_pkg::DIM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  out_width,
    input  logic [DIM_W-1:0]  out_height,
    input  logic [DIM_W-1:0]  out_pitch,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              write_done,
    output logic [ADDR_W-1:0] wr_count
);

    import conv_pkg::*;

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  width_q, height_q, pitch_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_count_q, wr_count_d;

    logic              load;
    logic              accept;
    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  row;
    logic [ADDR_W-1:0] row_base;
    logic              last;

    assign load   = (state_q == IDLE) && start;
    assign accept = (state_q == RUN) && in_valid;

    addr_walk_2d #(
        .DIM_W (DIM_W),
        .ADDR_W(ADDR_W)
    ) u_walk (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .base_i    (base_addr),
        .step_i    (accept),
        .width_i   (width_q),
        .height_i  (height_q),
        .pitch_i   (pitch_q),
        .col_o     (col),
        .row_o     (row),
        .row_base_o(row_base),
        .last_o    (last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if ((out_width == '0) || (out_height == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept && last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d       = accept;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_count_d = wr_count_q;
        if (accept) begin
            wr_addr_d  = row_base + ADDR_W'(col);
            wr_data_d  = in_data;
            wr_count_d = wr_count_q + ADDR_W'(1);
        end else if (load) begin
            wr_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            width_q    <= '0;
            height_q   <= '0;
            pitch_q    <= '0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_count_q <= wr_count_d;
            if (load) begin
                width_q  <= out_width;
                height_q <= out_height;
                pitch_q  <= out_pitch;
            end
        end
    end

    assign in_ready   = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign write_done = (state_q == DONE);
    assign we         = we_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_conv_out_writer.sv
// Randomised bench for conv_out_writer; expected writes come from a direct
// row-major address formula (base + row*pitch + col mod 2^18).
module tb_conv_out_writer;

    localparam int AW = 18;
    localparam int DW = 18;
    localparam int DMW = 9;

    logic          clk = 1'b0;
    logic          reset, start, in_valid;
    logic [DMW-1:0] out_width, out_height, out_pitch;
    logic [AW-1:0] base_addr;
    logic [DW-1:0] in_data;
    logic          in_ready, we, busy, write_done;
    logic [AW-1:0] wr_addr, wr_count;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    conv_out_writer #(.DATA_W(DW), .ADDR_W(AW), .DIM_W(DMW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .out_width(out_width), .out_height(out_height), .out_pitch(out_pitch),
        .base_addr(base_addr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .write_done(write_done), .wr_count(wr_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] dat[$];
    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    int n_done, done_cyc, ready_seen, lat_err, busy_after_done, wc_at_done, done_addr, we_at_done;

    function automatic logic [AW-1:0] model_addr(int b, int p, int r, int c);
        longint s;
        s = longint'(b) + longint'(r) * longint'(p) + longint'(c);
        return AW'(s % 262144);
    endfunction

    function automatic logic vpat(int mode, int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_frame(input int w, input int h, input int p, input int b, input int mode,
                             input int rnd, input int restart_at, input int max_cyc);
        int   idx;
        int   n;
        logic acc;
        bit   after;
        idx = 0; n = w * h; after = 0;
        dat.delete(); obs_addr.delete(); obs_data.delete();
        n_done = 0; done_cyc = -1; ready_seen = 0; lat_err = 0;
        busy_after_done = 1; wc_at_done = -1; done_addr = -1; we_at_done = 0;
        for (int i = 0; i < n; i++) dat.push_back(rnd != 0 ? DW'($urandom) : DW'(i + 1));
        @(negedge clk);
        out_width = DMW'(w); out_height = DMW'(h); out_pitch = DMW'(p); base_addr = AW'(b);
        start = 1'b1;
        in_valid = vpat(mode, 0);
        in_data = (n > 0) ? dat[0] : '0;
        for (int k = 0; k < max_cyc; k++) begin
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (we !== acc) lat_err++;
            if (we === 1'b1) begin obs_addr.push_back(wr_addr); obs_data.push_back(wr_data); end
            if (in_ready === 1'b1) ready_seen++;
            if (after) begin busy_after_done = int'(busy); break; end
            if (write_done === 1'b1) begin
                n_done++; done_cyc = k; wc_at_done = int'(wr_count);
                done_addr = int'(wr_addr); we_at_done = int'(we); after = 1;
            end
            if (acc) idx++;
            // Config inputs are don't-care once latched: scramble them.
            out_width = DMW'($urandom); out_height = DMW'($urandom);
            out_pitch = DMW'($urandom); base_addr = AW'($urandom);
            if (k == restart_at) begin
                start = 1'b1; base_addr = AW'(b + 1000); out_width = DMW'(w + 1); out_height = DMW'(h);
            end
            in_valid = (idx < n || n == 0) && vpat(mode, k + 1);
            in_data = (idx < n) ? dat[idx] : '0;
        end
        start = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        out_width = '0; out_height = '0; out_pitch = '0; base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({we, busy, write_done, in_ready} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=0000", {we, busy, write_done, in_ready});
        end
        n_cmp++;
        if ({wr_addr, wr_data, wr_count} !== '0) begin
            n_bad++; $display("FAIL reset_regs got addr=%0d data=%0d cnt=%0d exp 0/0/0", wr_addr, wr_data, wr_count);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_basic;
        run_frame(3, 2, 5, 100, 0, 0, -1, 50);
        n_cmp++;
        if (obs_addr.size() !== 6) begin n_bad++; $display("FAIL basic_nwrites got=%0d exp=6", obs_addr.size()); end
        for (int i = 0; i < 6; i++) begin
            logic [AW-1:0] ea;
            ea = model_addr(100, 5, i / 3, i % 3);
            n_cmp++;
            if (obs_addr[i] !== ea || obs_data[i] !== DW'(i + 1)) begin
                n_bad++; $display("FAIL basic_write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d",
                                  i, obs_addr[i], obs_data[i], ea, i + 1);
            end
        end
        n_cmp++;
        if (n_done !== 1 || we_at_done !== 1 || done_addr !== 107) begin
            n_bad++; $display("FAIL basic_done got n=%0d we=%0d addr=%0d exp 1/1/107", n_done, we_at_done, done_addr);
        end
        n_cmp++;
        if (wc_at_done !== 6) begin n_bad++; $display("FAIL basic_count got=%0d exp=6", wc_at_done); end
        n_cmp++;
        if (busy_after_done !== 0) begin n_bad++; $display("FAIL basic_busy_fall got=%0d exp=0", busy_after_done); end
        n_cmp++;
        if (lat_err !== 0 || done_cyc !== 6) begin
            n_bad++; $display("FAIL basic_latency got errs=%0d done_cyc=%0d exp 0/6", lat_err, done_cyc);
        end
    endtask

    task automatic test_toggle;
        run_frame(3, 2, 5, 100, 1, 0, -1, 80);
        n_cmp++;
        if (obs_addr.size() !== 6) begin n_bad++; $display("FAIL toggle_nwrites got=%0d exp=6", obs_addr.size()); end
        for (int i = 0; i < 6; i++) begin
            logic [AW-1:0] ea;
            ea = model_addr(100, 5, i / 3, i % 3);
            n_cmp++;
            if (obs_addr[i] !== ea || obs_data[i] !== DW'(i + 1)) begin
                n_bad++; $display("FAIL toggle_write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d",
                                  i, obs_addr[i], obs_data[i], ea, i + 1);
            end
        end
        n_cmp++;
        if (lat_err !== 0 || wc_at_done !== 6 || n_done !== 1) begin
            n_bad++; $display("FAIL toggle_we_track got errs=%0d cnt=%0d n_done=%0d exp 0/6/1", lat_err, wc_at_done, n_done);
        end
    endtask

    task automatic test_zero_dim;
        int dims[2][2];
        dims = '{'{0, 4}, '{5, 0}};
        for (int t = 0; t < 2; t++) begin
            run_frame(dims[t][0], dims[t][1], 3, 40, 0, 0, -1, 10);
            n_cmp++;
            if (obs_addr.size() !== 0 || ready_seen !== 0 || wc_at_done !== 0) begin
                n_bad++; $display("FAIL zero_dim%0d got writes=%0d ready=%0d cnt=%0d exp 0/0/0",
                                  t, obs_addr.size(), ready_seen, wc_at_done);
            end
            n_cmp++;
            if (n_done !== 1 || done_cyc < 0 || done_cyc > 1) begin
                n_bad++; $display("FAIL zero_dim%0d_done got n=%0d cyc=%0d exp 1 pulse within 2 cycles", t, n_done, done_cyc);
            end
        end
    endtask

    task automatic test_wrap;
        run_frame(4, 1, 9, 262142, 2, 1, -1, 60);
        n_cmp++;
        if (obs_addr.size() !== 4) begin n_bad++; $display("FAIL wrap_nwrites got=%0d exp=4", obs_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            int ea;
            ea = (i < 2) ? 262142 + i : i - 2;
            n_cmp++;
            if (obs_addr[i] !== AW'(ea) || obs_data[i] !== dat[i]) begin
                n_bad++; $display("FAIL wrap_write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d",
                                  i, obs_addr[i], obs_data[i], ea, dat[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int   accepted;
        int   stray;
        logic acc;
        accepted = 0; stray = 0;
        @(negedge clk);
        out_width = 4; out_height = 4; out_pitch = 8; base_addr = 50; start = 1'b1;
        in_valid = 1'b1; in_data = 18'h111;
        for (int k = 0; k < 40 && accepted < 5; k++) begin
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) begin accepted++; in_data = in_data + 1'b1; end
        end
        n_cmp++;
        if (accepted !== 5) begin n_bad++; $display("FAIL rstmid_accepts got=%0d exp=5", accepted); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if ({we, busy, write_done, in_ready} !== 4'b0000 || {wr_addr, wr_data, wr_count} !== '0) begin
            n_bad++; $display("FAIL rstmid_outputs got flags=%b addr=%0d data=%0d cnt=%0d exp all 0",
                              {we, busy, write_done, in_ready}, wr_addr, wr_data, wr_count);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (we !== 1'b0 || write_done !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin n_bad++; $display("FAIL rstmid_quiet got stray=%0d exp=0", stray); end
        in_valid = 1'b0;
        run_frame(2, 2, 3, 7, 0, 1, -1, 40);
        n_cmp++;
        if (obs_addr.size() !== 4 || wc_at_done !== 4) begin
            n_bad++; $display("FAIL rstmid_restart got writes=%0d cnt=%0d exp 4/4", obs_addr.size(), wc_at_done);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs_addr[i] !== model_addr(7, 3, i / 2, i % 2) || obs_data[i] !== dat[i]) begin
                n_bad++; $display("FAIL rstmid_write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d",
                                  i, obs_addr[i], obs_data[i], model_addr(7, 3, i / 2, i % 2), dat[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        int bad;
        bad = 0;
        run_frame(4, 4, 6, 300, 0, 1, 4, 100);
        n_cmp++;
        if (obs_addr.size() !== 16 || wc_at_done !== 16 || n_done !== 1) begin
            n_bad++; $display("FAIL restart_count got writes=%0d cnt=%0d n_done=%0d exp 16/16/1",
                              obs_addr.size(), wc_at_done, n_done);
        end
        for (int i = 0; i < 16; i++)
            if (obs_addr[i] !== model_addr(300, 6, i / 4, i % 4) || obs_data[i] !== dat[i]) bad++;
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL restart_stream got bad_writes=%0d exp=0", bad); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 4; t++) begin
            int w, h, p, b, n, bad;
            w = $urandom_range(1, 5); h = $urandom_range(1, 4);
            p = $urandom_range(0, 9); b = int'($urandom_range(0, 262143));
            n = w * h; bad = 0;
            run_frame(w, h, p, b, 2, 1, -1, 300);
            n_cmp++;
            if (obs_addr.size() !== n || wc_at_done !== n || n_done !== 1 || lat_err !== 0) begin
                n_bad++; $display("FAIL rand%0d_frame got writes=%0d cnt=%0d n_done=%0d lat=%0d exp %0d/%0d/1/0",
                                  t, obs_addr.size(), wc_at_done, n_done, lat_err, n, n);
            end
            for (int i = 0; i < n; i++)
                if (obs_addr[i] !== model_addr(b, p, i / w, i % w) || obs_data[i] !== dat[i]) bad++;
            n_cmp++;
            if (bad !== 0) begin
                n_bad++; $display("FAIL rand%0d_stream w=%0d h=%0d p=%0d b=%0d got bad_writes=%0d exp=0", t, w, h, p, b, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_zero_dim();
        test_wrap();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
